banco_dump: RTL and testbench

- Downstream consumer of the 8x16 operation-result register bank.
- On a start pulse, walks the bank's read select from 0 to NREG-1 and captures each combinational read word.
- Streams each word out over a valid/ready handshake, with its index and a last flag.
- Keeps a running 16-bit wrap-around checksum of the words sent and pulses done at the end.

---
 rtl/banco_dump_if.sv | 33 +++
 rtl/banco_dump.sv | 99 +++++++++
 tb/tb_banco_dump.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/banco_dump_if.sv
`default_nettype none
// ============================================================================
//  banco_dump_if
//  Bank read port plus word-stream handshake between banco_dump and consumer.
//  Rev 1.0
// ============================================================================
interface banco_dump_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] SEL;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] dout_idx;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    modport slave (
        input  start, R, dout_ready,
        output SEL, dout, dout_idx, dout_valid, dout_last, busy, done, checksum
    );

    modport master (
        output start, R, dout_ready,
        input  SEL, dout, dout_idx, dout_valid, dout_last, busy, done, checksum
    );
endinterface
`default_nettype wire

// File: rtl/banco_dump.sv
`default_nettype none
// ============================================================================
//  banco_dump
//  Walks the register bank select, streams each word out with index/last and
//  accumulates a wrap-around checksum of the accepted words.
//  Rev 1.0
// ============================================================================
module banco_dump #(
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  wire          clk,
    input  wire          reset,
    banco_dump_if.slave  bus
);
    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_dout;
    logic [ADDR_W-1:0] r_dout_idx;
    logic              r_dout_valid;
    logic              r_dout_last;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dout       <= '0;
            r_dout_idx   <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_checksum   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (bus.start) begin
                        r_checksum <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                // SEL has been stable for a full cycle, so R is settled here
                S_LOAD: begin
                    r_dout       <= bus.R;
                    r_dout_idx   <= r_idx;
                    r_dout_last  <= (r_idx == c_LAST_IDX);
                    r_dout_valid <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (r_dout_valid && bus.dout_ready) begin
                        r_checksum   <= r_checksum + r_dout;
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                        if (r_idx == c_LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.SEL        = r_idx;
    assign bus.dout       = r_dout;
    assign bus.dout_idx   = r_dout_idx;
    assign bus.dout_valid = r_dout_valid;
    assign bus.dout_last  = r_dout_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.checksum   = r_checksum;
endmodule
`default_nettype wire

// File: tb/tb_banco_dump.sv
`default_nettype none
// ============================================================================
//  tb_banco_dump
//  Self-checking bench: bank model drives R, scoreboard follows the stream.
//  Rev 1.0
// ============================================================================
module tb_banco_dump;
    localparam int NREG   = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic clk;
    logic rst_n;
    logic [DATA_W-1:0] bank [NREG];
    int errors = 0;
    int checks = 0;

    banco_dump_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    banco_dump #(.NREG(NREG), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    assign bus.R = bank[bus.SEL];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_ramp();
        for (int k = 0; k < NREG; k++) bank[k] = DATA_W'(k * 16'h0101);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.SEL, bus.dout, bus.dout_idx, bus.dout_valid, bus.dout_last,
             bus.busy, bus.done, bus.checksum} !== '0) begin
            errors++;
            $display("FAIL %s: outputs sel=%h dout=%h idx=%h v=%b l=%b busy=%b done=%b cs=%h, required all 0",
                     tag, bus.SEL, bus.dout, bus.dout_idx, bus.dout_valid, bus.dout_last,
                     bus.busy, bus.done, bus.checksum);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dout_ready = 1'b0;
        for (int k = 0; k < NREG; k++) bank[k] = '0;
        #1 check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release_idle");
    endtask

    // Cycle-exact timing with ready tied high: word k valid in cycle 2+2k
    task automatic test_basic();
        bit            exp_v;
        int            k;
        logic [15:0]   exp_sum;
        fill_ramp();
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        exp_sum = '0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            exp_v = (c >= 2) && (c <= 16) && (c % 2 == 0);
            k = (c - 2) / 2;
            checks++;
            if (bus.dout_valid !== exp_v) begin
                errors++;
                $display("FAIL basic_valid c=%0d: got %b need %b", c, bus.dout_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (bus.dout !== DATA_W'(k * 16'h0101) || bus.dout_idx !== ADDR_W'(k)) begin
                    errors++;
                    $display("FAIL basic_word c=%0d: got %h/%0d need %h/%0d",
                             c, bus.dout, bus.dout_idx, k * 16'h0101, k);
                end
            end
            checks++;
            if (bus.dout_last !== (c == 16)) begin
                errors++;
                $display("FAIL basic_last c=%0d: got %b need %b", c, bus.dout_last, c == 16);
            end
            checks++;
            if (bus.done !== (c == 17) || bus.busy !== (c <= 17)) begin
                errors++;
                $display("FAIL basic_done_busy c=%0d: got done=%b busy=%b need done=%b busy=%b",
                         c, bus.done, bus.busy, c == 17, c <= 17);
            end
            if (c >= 17) begin
                checks++;
                if (bus.checksum !== 16'h1C1C) begin
                    errors++;
                    $display("FAIL basic_checksum c=%0d: got %h need 1c1c", c, bus.checksum);
                end
            end
        end
    endtask

    // Scoreboard-driven dump.
    // mode: 0 ready=1, 1 random ready, 2 stall word 3 for 5 cycles
    task automatic run_dump(input int mode, input bit start_noise, input bit mutate,
                            input int exp_cs, input bit tail, input string tag);
        int          n_acc = 0;
        int          cyc = 0;
        int          stall = 0;
        int          last_hs = 0;
        int          cur;
        bit          seen = 0;
        bit          fin = 0;
        logic [15:0] sum = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dout_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus.start = start_noise && ($urandom_range(0, 2) == 0);
            checks++;
            if (bus.checksum !== sum || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_running cyc=%0d: got cs=%h busy=%b need cs=%h busy=1",
                         tag, cyc, bus.checksum, bus.busy, sum);
            end
            if (bus.done) begin
                fin = 1;
                checks++;
                if (n_acc != NREG || cyc != last_hs + 1) begin
                    errors++;
                    $display("FAIL %s_done cyc=%0d: got words=%0d need %0d at cyc %0d",
                             tag, cyc, n_acc, NREG, last_hs + 1);
                end
            end else if (bus.dout_valid) begin
                cur = n_acc;
                if (!seen) begin
                    seen = 1;
                    checks++;
                    if (cyc != ((cur == 0) ? 2 : last_hs + 2)) begin
                        errors++;
                        $display("FAIL %s_latency word=%0d: got cyc %0d need %0d",
                                 tag, cur, cyc, (cur == 0) ? 2 : last_hs + 2);
                    end
                end
                checks++;
                if (cur >= NREG || bus.dout !== bank[cur] || bus.dout_idx !== ADDR_W'(cur) ||
                    bus.SEL !== ADDR_W'(cur) || bus.dout_last !== (cur == NREG - 1)) begin
                    errors++;
                    $display("FAIL %s_word cyc=%0d: got d=%h idx=%0d sel=%0d last=%b need d=%h idx=%0d last=%b",
                             tag, cyc, bus.dout, bus.dout_idx, bus.SEL, bus.dout_last,
                             (cur < NREG) ? bank[cur] : 16'h0, cur, cur == NREG - 1);
                end
                case (mode)
                    1:       bus.dout_ready = 1'($urandom_range(0, 1));
                    2: begin
                        bus.dout_ready = !(cur == 3 && stall < 5);
                        if (cur == 3 && stall < 5) stall++;
                    end
                    default: bus.dout_ready = 1'b1;
                endcase
                if (mutate && cur < NREG - 1)
                    bank[$urandom_range(cur + 1, NREG - 1)] = 16'($urandom);
                if (bus.dout_ready) begin
                    sum = sum + bus.dout;
                    n_acc++;
                    last_hs = cyc;
                    seen = 0;
                end
            end else begin
                if (mode == 1) bus.dout_ready = 1'($urandom_range(0, 1));
                checks++;
                if (bus.dout_last !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_last_novalid cyc=%0d: got %b need 0", tag, cyc, bus.dout_last);
                end
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, cyc);
        end
        if (mode == 2) begin
            checks++;
            if (stall != 5) begin
                errors++;
                $display("FAIL %s_stall: got %0d stalled cycles need 5", tag, stall);
            end
        end
        if (exp_cs >= 0) begin
            checks++;
            if (bus.checksum !== 16'(exp_cs)) begin
                errors++;
                $display("FAIL %s_final_cs: got %h need %h", tag, bus.checksum, 16'(exp_cs));
            end
        end
        if (start_noise) bus.start = 1'b1;
        @(posedge clk);
        if (tail) begin
            @(negedge clk);
            bus.start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dout_valid !== 1'b0 ||
                    bus.checksum !== sum) begin
                    errors++;
                    $display("FAIL %s_idle_after i=%0d: got busy=%b done=%b v=%b cs=%h need 0/0/0/%h",
                             tag, i, bus.busy, bus.done, bus.dout_valid, bus.checksum, sum);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_checksum_wrap();
        for (int k = 0; k < NREG; k++) bank[k] = 16'hFFFF;
        run_dump(0, 0, 0, 32'h0000FFF8, 1, "wrap");
    endtask

    task automatic test_backpressure();
        fill_ramp();
        run_dump(2, 0, 0, 32'h00001C1C, 1, "bp");
    endtask

    task automatic test_start_while_busy();
        fill_ramp();
        run_dump(0, 1, 0, 32'h00001C1C, 1, "busy_start");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < NREG; k++) bank[k] = 16'($urandom);
            run_dump(1, 1, 1, -1, 1, "random");
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found = 0;
        fill_ramp();
        bus.dout_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.dout_valid && bus.dout_idx == 3'd4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midreset_reach: word 4 never seen valid");
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset_async");
        @(negedge clk);
        check_all_zero("midreset_held");
        rst_n = 1'b1;
        run_dump(0, 0, 0, 32'h00001C1C, 1, "after_reset");
    endtask

    task automatic test_back_to_back();
        fill_ramp();
        run_dump(0, 0, 0, 32'h00001C1C, 0, "b2b_first");
        run_dump(0, 0, 0, 32'h00001C1C, 1, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_checksum_wrap();
        test_backpressure();
        test_start_while_busy();
        test_random();
        test_reset_mid_dump();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
